core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
- Multi-cycle sequencer directly upstream of the ALU.
- Fetches a 9-bit instruction and decodes it into alu_cmd, register-file addresses and an immediate.
- Latches the ALU equal/zero flags, resolves branches through a branch-target LUT, and runs a req/ack handshake to data memory for LD/ST.
- Sits between instruction ROM, register file, ALU and data memory.

Parameters:
- PC_W, 10, program counter width.
- LUT_N, 32, branch-target LUT entries, indexed by 5-bit field.
- WDOG_MAX, 255, watchdog cycle limit (optional feature only).

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE
- start  in  1  level; leave IDLE and begin fetch at pc=0
- instr  in  9  instruction ROM data at address pc, combinational
- alu_equal  in  1  ALU equality flag
- alu_zero  in  1  ALU zero flag
- dmem_ack  in  1  data-memory completion, one-cycle pulse
- pc  out  PC_W  fetch address
- alu_cmd  out  4  ALU opcode
- ra_addr  out  3  register-file read A / destination
- rb_addr  out  3  register-file read B
- imm  out  8  zero-extended immediate
- imm_sel  out  1  ALU B input = imm
- rf_we  out  1  register-file write strobe, exactly one cycle
- dmem_req  out  1  data-memory request
- dmem_we  out  1  1 = store, 0 = load
- flag_eq  out  1  latched equal flag
- done  out  1  program halted
- err  out  1  watchdog abort (tied 0 without the optional feature)

Behaviour:
- Encoding:
  - op=instr[8:5]; rd=instr[4:3] (R0–R3, drives ra_addr as {1'b0,rd}); rs=instr[2:0].
  - imm={5'b0,instr[2:0]}; branch index=instr[4:0].
- ALU opcodes passed through on alu_cmd: 0000 ADD, 0001 SHL, 0010 SHR, 0011 MOV, 0100 OR, 0101 XOR, 0110 AND, 0111 ADDI, 1010 MOVI, 1101 CMP, 1111 NOP.
- Controller-only opcodes: 1000 LD, 1001 ST, 1011 BEQ, 1100 BNE, 1110 HALT; alu_cmd=1111 for these.
- Reset values: pc=0, state=IDLE, flag_eq=0, done=0, err=0.
  - All strobes (rf_we, dmem_req, dmem_we, imm_sel) are 0.
  - alu_cmd=4'b1111, addresses and imm are 0.
- States: IDLE -> FETCH -> DECODE -> EXEC -> {MEM} -> WB -> FETCH; HALT terminal.
  - IDLE: stay until start=1.
  - FETCH: register instr into IR.
  - DECODE: drive alu_cmd, addresses, imm and imm_sel (1 for ADDI, MOVI) from IR; held through WB.
  - EXEC: on CMP, flag_eq <= alu_equal. LD/ST go to MEM; HALT goes to HALT; all others go to WB.
  - MEM: dmem_req=1 and dmem_we=(op==ST) held until the cycle dmem_ack=1; then WB. An ack while not in MEM is ignored.
  - WB:
    - rf_we=1 for ALU ops except CMP and NOP, and for LD.
    - pc update: BEQ with flag_eq=1 or BNE with flag_eq=0 -> pc <= lut[index]; otherwise pc <= pc+1.
    - pc wraps modulo 2^PC_W.
  - HALT: done=1; remains until reset.
- Latency: 4 cycles per instruction; LD/ST take 4 + ack wait (at least 1 cycle).
- Reset wins over every other event. Reset during MEM drops dmem_req in the next cycle.
- start is ignored outside IDLE.
- flag_eq is only written by CMP; branches read the latched value.

Optional Feature:
- Macro CTRL_WATCHDOG_EN.
- Defined: an 8-bit counter runs in MEM. If no ack arrives within WDOG_MAX cycles, the FSM goes to HALT with err=1 and done=1, and dmem_req drops.
- Undefined: MEM waits indefinitely; err is constant 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode enum (4-bit, values above);
  - state enum;
  - field-slice constants;
  - NOP_CMD=4'b1111.
- Sub-module branch_lut: combinational LUT_N x PC_W table, index -> target, contents from a constant array.

Test Plan:
- Reset held 2 cycles, then start=1 with ROM[0]=ADD R1,R2 -> pc=0 after reset; one rf_we pulse at cycle 4 with alu_cmd=0000, ra_addr=1, rb_addr=2; pc becomes 1.
- ADDI R0,#5 -> imm=8'h05, imm_sel=1 from DECODE through WB, alu_cmd=0111.
- CMP with alu_equal=1, then BEQ idx 3 with lut[3]=20 -> flag_eq=1, pc=20. Repeat with alu_equal=0 -> pc increments by 1.
- LD with ack delayed 3 cycles -> dmem_req high exactly 3 cycles, dmem_we=0; rf_we pulses in the following WB; ST gives dmem_we=1 and no rf_we.
- HALT at pc=7 -> done=1 and pc stays 7. Then reset -> done=0, state IDLE.
- With CTRL_WATCHDOG_EN and no ack -> after WDOG_MAX cycles err=1, done=1, dmem_req=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the core control sequencer: opcodes, FSM
// states, instruction field positions and the branch-target table contents.
package ctrl_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SHL  = 4'b0001,
    OP_SHR  = 4'b0010,
    OP_MOV  = 4'b0011,
    OP_OR   = 4'b0100,
    OP_XOR  = 4'b0101,
    OP_AND  = 4'b0110,
    OP_ADDI = 4'b0111,
    OP_LD   = 4'b1000,
    OP_ST   = 4'b1001,
    OP_MOVI = 4'b1010,
    OP_BEQ  = 4'b1011,
    OP_BNE  = 4'b1100,
    OP_CMP  = 4'b1101,
    OP_HALT = 4'b1110,
    OP_NOP  = 4'b1111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam int unsigned OP_MSB  = 8;
  localparam int unsigned OP_LSB  = 5;
  localparam int unsigned RD_MSB  = 4;
  localparam int unsigned RD_LSB  = 3;
  localparam int unsigned RS_MSB  = 2;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IDX_MSB = 4;
  localparam int unsigned IDX_LSB = 0;

  localparam logic [3:0] NOP_CMD = 4'b1111;

  localparam int unsigned LUT_DEPTH = 32;
  localparam logic [9:0] LUT_TABLE [LUT_DEPTH] = '{
    10'd8,   10'd12,  10'd16,  10'd20,  10'd24,  10'd28,  10'd32,  10'd36,
    10'd40,  10'd44,  10'd48,  10'd52,  10'd56,  10'd60,  10'd64,  10'd68,
    10'd72,  10'd76,  10'd80,  10'd84,  10'd88,  10'd92,  10'd96,  10'd100,
    10'd104, 10'd108, 10'd112, 10'd116, 10'd120, 10'd124, 10'd128, 10'd132
  };

  // Opcodes handled by the controller itself; the ALU sees NOP for these.
  function automatic logic is_ctrl_op(input opcode_e op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_HALT);
  endfunction

  function automatic logic writes_rf(input opcode_e op);
    return (op == OP_LD) ||
           (!is_ctrl_op(op) && (op != OP_CMP) && (op != OP_NOP));
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_branch_lut.sv
// Combinational branch-target table: 5-bit index to PC_W-bit target address.
module branch_lut
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned LUT_N = 32
) (
  input  logic [4:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  always_comb begin
    target_o = '0;
    if (32'(idx_i) < LUT_N) begin
      target_o = PC_W'(LUT_TABLE[idx_i]);
    end
  end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer in front of the ALU, with branch
// LUT and data-memory req/ack. Optional MEM watchdog: define CTRL_WATCHDOG_EN.
module core_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = 10,
  parameter int unsigned LUT_N    = 32,
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic            alu_equal,
  input  logic            alu_zero,
  input  logic            dmem_ack,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      alu_cmd,
  output logic [2:0]      ra_addr,
  output logic [2:0]      rb_addr,
  output logic [7:0]      imm,
  output logic            imm_sel,
  output logic            rf_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            flag_eq,
  output logic            done,
  output logic            err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [8:0]      ir_q, ir_d;
  logic            flag_eq_q, flag_eq_d;
  logic            flag_zero_q, flag_zero_d;
  opcode_e         op;
  logic [PC_W-1:0] br_target;
  logic            take_branch;
  logic            active;

`ifdef CTRL_WATCHDOG_EN
  logic [7:0] wdog_q, wdog_d;
  logic       err_q, err_d;
`endif

  assign op          = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign take_branch = ((op == OP_BEQ) && flag_eq_q) ||
                       ((op == OP_BNE) && !flag_eq_q);
  assign active      = (state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                       (state_q == ST_MEM)    || (state_q == ST_WB);

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_N (LUT_N)
  ) u_branch_lut (
    .idx_i    (ir_q[IDX_MSB:IDX_LSB]),
    .target_o (br_target)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    flag_eq_d   = flag_eq_q;
    flag_zero_d = flag_zero_q;
`ifdef CTRL_WATCHDOG_EN
    wdog_d      = wdog_q;
    err_d       = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
        end
      end
      ST_FETCH: begin
        ir_d    = instr;
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (op == OP_CMP) begin
          flag_eq_d   = alu_equal;
          flag_zero_d = alu_zero;
        end
        if ((op == OP_LD) || (op == OP_ST)) begin
          state_d = ST_MEM;
`ifdef CTRL_WATCHDOG_EN
          wdog_d  = '0;
`endif
        end else if (op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          state_d = ST_WB;
        end
`ifdef CTRL_WATCHDOG_EN
        // Counter value k means k+1 MEM cycles elapsed without an ack.
        else if (wdog_q == 8'(WDOG_MAX - 1)) begin
          state_d = ST_HALT;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 8'd1;
        end
`endif
      end
      ST_WB: begin
        pc_d    = take_branch ? br_target : pc_q + PC_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      flag_eq_q   <= 1'b0;
      flag_zero_q <= 1'b0;
`ifdef CTRL_WATCHDOG_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      flag_eq_q   <= flag_eq_d;
      flag_zero_q <= flag_zero_d;
`ifdef CTRL_WATCHDOG_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    alu_cmd = NOP_CMD;
    ra_addr = '0;
    rb_addr = '0;
    imm     = '0;
    imm_sel = 1'b0;
    if (active) begin
      if (!is_ctrl_op(op)) begin
        alu_cmd = op;
      end
      ra_addr = {1'b0, ir_q[RD_MSB:RD_LSB]};
      rb_addr = ir_q[RS_MSB:RS_LSB];
      imm     = {5'b0, ir_q[RS_MSB:RS_LSB]};
      imm_sel = (op == OP_ADDI) || (op == OP_MOVI);
    end
  end

  assign pc       = pc_q;
  assign flag_eq  = flag_eq_q;
  assign rf_we    = (state_q == ST_WB) && writes_rf(op);
  assign dmem_req = (state_q == ST_MEM);
  assign dmem_we  = (state_q == ST_MEM) && (op == OP_ST);
  assign done     = (state_q == ST_HALT);
`ifdef CTRL_WATCHDOG_EN
  assign err      = err_q;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed self-checking bench for core_ctrl_fsm with a behavioural ROM.
module tb_core_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset, start, alu_equal, alu_zero, dmem_ack;
  logic [8:0] instr;
  logic [9:0] pc;
  logic [3:0] alu_cmd;
  logic [2:0] ra_addr, rb_addr;
  logic [7:0] imm;
  logic       imm_sel, rf_we, dmem_req, dmem_we, flag_eq, done, err;

  logic [8:0] rom [1024];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign instr = rom[pc];

  core_ctrl_fsm #(.PC_W(10), .LUT_N(32), .WDOG_MAX(255)) dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .alu_equal(alu_equal), .alu_zero(alu_zero), .dmem_ack(dmem_ack),
    .pc(pc), .alu_cmd(alu_cmd), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .imm(imm), .imm_sel(imm_sel), .rf_we(rf_we), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .flag_eq(flag_eq), .done(done), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 9'b1111_00_000;
  endtask

  // Reset for two cycles, release with start; returns with the FSM in FETCH of pc 0.
  task automatic boot();
    reset = 1'b1; start = 1'b0; dmem_ack = 1'b0;
    tick(); tick();
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dmem_ack = 1'b0; alu_equal = 1'b0; alu_zero = 1'b0;
    tick(); tick();
    n_vec++; if (pc !== 10'd0) begin n_err++; $display("FAIL rst_pc: got %0d want 0", pc); end
    n_vec++; if (alu_cmd !== 4'hf) begin n_err++; $display("FAIL rst_alu_cmd: got %0h want f", alu_cmd); end
    n_vec++; if ({ra_addr, rb_addr, imm} !== 14'd0) begin n_err++; $display("FAIL rst_addr_imm: got %0h want 0", {ra_addr, rb_addr, imm}); end
    n_vec++; if ({rf_we, dmem_req, dmem_we, imm_sel} !== 4'b0000) begin n_err++; $display("FAIL rst_strobes: got %b want 0000", {rf_we, dmem_req, dmem_we, imm_sel}); end
    n_vec++; if ({flag_eq, done, err} !== 3'b000) begin n_err++; $display("FAIL rst_flags: got %b want 000", {flag_eq, done, err}); end
  endtask

  task automatic test_add();
    int we_cnt;
    clear_rom();
    rom[0] = 9'b0000_01_010;
    boot();
    we_cnt = int'(rf_we);
    n_vec++; if (alu_cmd !== 4'hf) begin n_err++; $display("FAIL add_fetch_cmd: got %0h want f", alu_cmd); end
    start = 1'b1;  // ignored outside IDLE
    tick();
    we_cnt += int'(rf_we);
    n_vec++; if ({alu_cmd, ra_addr, rb_addr} !== {4'h0, 3'd1, 3'd2}) begin n_err++; $display("FAIL add_decode: got %h want %h", {alu_cmd, ra_addr, rb_addr}, {4'h0, 3'd1, 3'd2}); end
    tick();
    we_cnt += int'(rf_we);
    tick();
    n_vec++; if ({rf_we, alu_cmd, pc} !== {1'b1, 4'h0, 10'd0}) begin n_err++; $display("FAIL add_wb: got %h want %h", {rf_we, alu_cmd, pc}, {1'b1, 4'h0, 10'd0}); end
    we_cnt += int'(rf_we);
    tick();
    we_cnt += int'(rf_we);
    start = 1'b0;
    n_vec++; if (pc !== 10'd1) begin n_err++; $display("FAIL add_pc_next: got %0d want 1", pc); end
    n_vec++; if (we_cnt !== 1) begin n_err++; $display("FAIL add_we_pulses: got %0d want 1", we_cnt); end
  endtask

  task automatic test_addi();
    clear_rom();
    rom[0] = 9'b0111_00_101;
    boot();
    n_vec++; if (imm_sel !== 1'b0) begin n_err++; $display("FAIL addi_fetch_sel: got %b want 0", imm_sel); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if ({imm_sel, imm, alu_cmd, ra_addr} !== {1'b1, 8'h05, 4'h7, 3'd0}) begin n_err++; $display("FAIL addi_hold_c%0d: got %h want %h", c, {imm_sel, imm, alu_cmd, ra_addr}, {1'b1, 8'h05, 4'h7, 3'd0}); end
    end
    n_vec++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL addi_we: got %b want 1", rf_we); end
    tick();
    n_vec++; if ({imm_sel, pc} !== {1'b0, 10'd1}) begin n_err++; $display("FAIL addi_after: got %h want %h", {imm_sel, pc}, {1'b0, 10'd1}); end
  endtask

  task automatic test_branch(input logic eq, input logic [3:0] bop, input logic [9:0] exp_pc);
    clear_rom();
    rom[0] = 9'b1101_00_001;
    rom[1] = {bop, 5'd3};
    alu_equal = eq;
    boot();
    tick(); tick(); tick();
    n_vec++; if ({flag_eq, rf_we} !== {eq, 1'b0}) begin n_err++; $display("FAIL br_cmp_flag op%h eq%b: got %b want %b", bop, eq, {flag_eq, rf_we}, {eq, 1'b0}); end
    alu_equal = ~eq;  // branch must use the latched flag
    tick(); tick(); tick(); tick();
    n_vec++; if ({rf_we, alu_cmd} !== {1'b0, 4'hf}) begin n_err++; $display("FAIL br_wb op%h eq%b: got %h want %h", bop, eq, {rf_we, alu_cmd}, {1'b0, 4'hf}); end
    tick();
    n_vec++; if ({pc, flag_eq} !== {exp_pc, eq}) begin n_err++; $display("FAIL br_pc op%h eq%b: got %0d/%b want %0d/%b", bop, eq, pc, flag_eq, exp_pc, eq); end
  endtask

  task automatic test_mem();
    int cnt;
    clear_rom();
    rom[0] = 9'b1000_10_000;
    rom[1] = 9'b1001_01_000;
    rom[2] = 9'b1000_11_000;
    boot();
    tick(); tick(); tick();
    cnt = 0;
    while (dmem_req === 1'b1 && cnt < 8) begin
      cnt++;
      n_vec++; if ({dmem_we, rf_we, err} !== 3'b000) begin n_err++; $display("FAIL ld_mem_c%0d: got %b want 000", cnt, {dmem_we, rf_we, err}); end
      dmem_ack = (cnt == 3);
      tick();
      dmem_ack = 1'b0;
    end
    n_vec++; if (cnt !== 3) begin n_err++; $display("FAIL ld_req_cycles: got %0d want 3", cnt); end
    n_vec++; if ({rf_we, dmem_req, ra_addr} !== {1'b1, 1'b0, 3'd2}) begin n_err++; $display("FAIL ld_wb: got %h want %h", {rf_we, dmem_req, ra_addr}, {1'b1, 1'b0, 3'd2}); end
    tick();
    dmem_ack = 1'b1;  // stray ack outside MEM
    n_vec++; if (pc !== 10'd1) begin n_err++; $display("FAIL ld_pc: got %0d want 1", pc); end
    tick();
    dmem_ack = 1'b0;
    tick(); tick();
    n_vec++; if ({dmem_req, dmem_we} !== 2'b11) begin n_err++; $display("FAIL st_mem: got %b want 11", {dmem_req, dmem_we}); end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_vec++; if ({rf_we, dmem_req, dmem_we} !== 3'b000) begin n_err++; $display("FAIL st_wb: got %b want 000", {rf_we, dmem_req, dmem_we}); end
    tick();
    n_vec++; if (pc !== 10'd2) begin n_err++; $display("FAIL st_pc: got %0d want 2", pc); end
    tick(); tick(); tick();
    n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL ld2_mem: got %b want 1", dmem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if ({dmem_req, pc} !== {1'b0, 10'd0}) begin n_err++; $display("FAIL rst_in_mem: got %h want %h", {dmem_req, pc}, {1'b0, 10'd0}); end
  endtask

  task automatic test_halt();
    int we_cnt;
    clear_rom();
    rom[7] = 9'b1110_00_000;
    boot();
    we_cnt = 0;
    for (int i = 1; i <= 31; i++) begin
      tick();
      we_cnt += int'(rf_we);
      if (i == 30) begin
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", done); end
      end
    end
    n_vec++; if ({done, err, pc} !== {1'b1, 1'b0, 10'd7}) begin n_err++; $display("FAIL halt_state: got %h want %h", {done, err, pc}, {1'b1, 1'b0, 10'd7}); end
    n_vec++; if (we_cnt !== 0) begin n_err++; $display("FAIL nop_we: got %0d want 0", we_cnt); end
    start = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    n_vec++; if ({done, pc} !== {1'b1, 10'd7}) begin n_err++; $display("FAIL halt_sticky: got %h want %h", {done, pc}, {1'b1, 10'd7}); end
    rom[0] = 9'b0000_01_010;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++; if ({done, pc, alu_cmd} !== {1'b0, 10'd0, 4'hf}) begin n_err++; $display("FAIL halt_reset: got %h want %h", {done, pc, alu_cmd}, {1'b0, 10'd0, 4'hf}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if ({done, pc, alu_cmd} !== {1'b0, 10'd0, 4'hf}) begin n_err++; $display("FAIL idle_hold_c%0d: got %h want %h", c, {done, pc, alu_cmd}, {1'b0, 10'd0, 4'hf}); end
    end
  endtask

`ifdef CTRL_WATCHDOG_EN
  task automatic test_watchdog();
    int cnt;
    clear_rom();
    rom[0] = 9'b1000_00_000;
    boot();
    tick(); tick(); tick();
    cnt = 0;
    while (dmem_req === 1'b1 && cnt < 300) begin
      cnt++;
      tick();
    end
    n_vec++; if (cnt !== 255) begin n_err++; $display("FAIL wdog_cycles: got %0d want 255", cnt); end
    n_vec++; if ({err, done, dmem_req} !== 3'b110) begin n_err++; $display("FAIL wdog_abort: got %b want 110", {err, done, dmem_req}); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_branch(1'b1, 4'b1011, 10'd20);
    test_branch(1'b0, 4'b1011, 10'd2);
    test_branch(1'b0, 4'b1100, 10'd20);
    test_branch(1'b1, 4'b1100, 10'd2);
    test_mem();
    test_halt();
`ifdef CTRL_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
